// File: rtl/seqdet_pkg.sv
// Shared "101" overlapping sequence-detector state encoding and next-state function,
// usable by the channel scheduler and by any single-channel detector.
package seqdet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_S1   = 2'd1,
    ST_S10  = 2'd2,
    ST_S101 = 2'd3
  } seqdet_state_t;

  function automatic seqdet_state_t seqdet_next(input seqdet_state_t state, input logic bit_in);
    seqdet_state_t nxt;
    case (state)
      ST_IDLE: nxt = bit_in ? ST_S1   : ST_IDLE;
      ST_S1:   nxt = bit_in ? ST_S1   : ST_S10;
      ST_S10:  nxt = bit_in ? ST_S101 : ST_IDLE;
      ST_S101: nxt = bit_in ? ST_S1   : ST_S10;
      default: nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index at or above i_ptr,
// wrapping past N-1 to 0. Produces a one-hot grant plus the granted index.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_vld
);

  localparam int IDX_W = $clog2(N);

  // Wrap-around candidates are found first; candidates at or above the pointer override them.
  always_comb begin
    o_idx = '0;
    o_vld = |i_req;
    for (int i = N - 1; i >= 0; i--) begin
      o_idx = i_req[i] ? IDX_W'(i) : o_idx;
    end
    for (int i = N - 1; i >= 0; i--) begin
      o_idx = (i_req[i] && (i >= int'(i_ptr))) ? IDX_W'(i) : o_idx;
    end
    o_gnt = o_vld ? (N'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/seqdet_ch_sched.sv
// Round-robin shared "101" detector serving NUM_CH serial channels through a context table.
// Optional per-channel saturating match counters are enabled by defining SEQDET_MATCH_CNT_EN.
module seqdet_ch_sched #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         ch_valid,
  input  logic [NUM_CH-1:0]         ch_data,
  output logic [NUM_CH-1:0]         ch_ready,
  input  logic [NUM_CH-1:0]         ctx_clr,
`ifdef SEQDET_MATCH_CNT_EN
  input  logic                      cnt_clr,
  output logic [NUM_CH*CNT_W-1:0]   match_cnt,
`endif
  output logic                      match_vld,
  output logic [$clog2(NUM_CH)-1:0] match_ch,
  output logic [NUM_CH-1:0]         ch_match
);

  import seqdet_pkg::*;

  localparam int IDX_W = $clog2(NUM_CH);

  if (NUM_CH < 2 || CNT_W < 1) begin : g_param_chk
    $error("seqdet_ch_sched: NUM_CH must be >= 2 and CNT_W >= 1");
  end

  logic [NUM_CH-1:0] w_req;
  logic [NUM_CH-1:0] w_gnt;
  logic [IDX_W-1:0]  w_gnt_idx;
  logic              w_gnt_vld;
  logic [IDX_W-1:0]  w_ptr_nxt;
  logic              w_match;
  seqdet_state_t     w_base;
  seqdet_state_t     w_next;

  logic [IDX_W-1:0]  r_ptr;
  seqdet_state_t     r_ctx [NUM_CH];
  logic              r_match_vld;
  logic [IDX_W-1:0]  r_match_ch;
  logic [NUM_CH-1:0] r_ch_match;

  // Requests are suppressed while held in reset or disabled, so nothing is granted or lost.
  assign w_req = ch_valid & {NUM_CH{enable & rst_n}};

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx),
    .o_vld (w_gnt_vld)
  );

  assign ch_ready = w_gnt;

  // Shared engine: a same-cycle context clear makes the granted bit start from IDLE.
  always_comb begin
    w_base    = ctx_clr[w_gnt_idx] ? ST_IDLE : r_ctx[w_gnt_idx];
    w_next    = seqdet_next(w_base, ch_data[w_gnt_idx]);
    w_match   = w_gnt_vld && (w_next == ST_S101);
    w_ptr_nxt = (w_gnt_idx == IDX_W'(NUM_CH - 1)) ? '0 : (w_gnt_idx + IDX_W'(1));
  end

  // Context table write-back and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < NUM_CH; j++) begin
        r_ctx[j] <= ST_IDLE;
      end
      r_ptr <= '0;
    end else begin
      for (int j = 0; j < NUM_CH; j++) begin
        if (w_gnt[j]) begin
          r_ctx[j] <= w_next;
        end else if (ctx_clr[j]) begin
          r_ctx[j] <= ST_IDLE;
        end else begin
          r_ctx[j] <= r_ctx[j];
        end
      end
      if (w_gnt_vld) begin
        r_ptr <= w_ptr_nxt;
      end else begin
        r_ptr <= r_ptr;
      end
    end
  end

  // Registered match report, one cycle after the accepting edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_match_vld <= 1'b0;
      r_match_ch  <= '0;
      r_ch_match  <= '0;
    end else begin
      r_match_vld <= w_match;
      r_match_ch  <= w_match ? w_gnt_idx : '0;
      r_ch_match  <= w_match ? w_gnt : '0;
    end
  end

  assign match_vld = r_match_vld;
  assign match_ch  = r_match_ch;
  assign ch_match  = r_ch_match;

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] r_cnt [NUM_CH];

  // Saturating per-channel match counters; a clear beats a coincident match.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < NUM_CH; j++) begin
        r_cnt[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_CH; j++) begin
        if (cnt_clr) begin
          r_cnt[j] <= '0;
        end else if (w_match && w_gnt[j] && (r_cnt[j] != '1)) begin
          r_cnt[j] <= r_cnt[j] + CNT_W'(1);
        end else begin
          r_cnt[j] <= r_cnt[j];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt_out
    assign match_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
  end
`else
  // Counter build option off: no counters, no counter ports.
`endif

endmodule
